ttc_intr_sched25: RTL and testbench

//  Schedules the per-counter interrupts of the triple timer-counter onto one CPU interrupt line.

---
 rtl/ttc_intr_sched25.sv | 151 +++++++++++++++
 tb/tb_ttc_intr_sched25.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ttc_intr_sched25.sv
// Interrupt scheduler for the triple timer-counter: arbitrates the per-counter
// interrupt levels onto one CPU line and pulses the winner's clear after ack or timeout.
module ttc_intr_sched25 #(
    parameter int NUM_CNT     = 3,
    parameter int SRC_W       = 2,
    parameter int ACK_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic                 pclk25,
    input  logic                 p_reset25,
    input  logic [NUM_CNT-1:0]   cnt_intr25,
    input  logic [6*NUM_CNT-1:0] cnt_intr_reg25,
    input  logic                 sched_en25,
    input  logic                 prio_mode25,
    input  logic                 irq_ack25,
    input  logic                 timeout_clr25,
    output logic                 irq25,
    output logic [SRC_W-1:0]     irq_src25,
    output logic [5:0]           irq_status25,
    output logic [NUM_CNT-1:0]   clear_interrupt25,
    output logic                 timeout25
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        CLEAR  = 2'd2,
        WAIT   = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [TO_W-1:0]      count_q, count_d;
    logic [SRC_W-1:0]     last_q, last_d;
    logic                 irq_q, irq_d;
    logic [SRC_W-1:0]     src_q, src_d;
    logic [5:0]           status_q, status_d;
    logic [NUM_CNT-1:0]   clr_q, clr_d;
    logic                 timeout_q, timeout_d;

    logic                 winValid;
    logic [SRC_W-1:0]     winIdx;
    logic [5:0]           winStatus;
    int                   rrIdx;

    // Arbiter: loops run from the far end so the last match is the preferred winner.
    always_comb begin
        winValid  = |cnt_intr25;
        winIdx    = '0;
        rrIdx     = 0;
        if (!prio_mode25) begin
            for (int i = NUM_CNT - 1; i >= 0; i--) begin
                if ((cnt_intr25 & (NUM_CNT'(1) << i)) != '0) begin
                    winIdx = SRC_W'(i);
                end
            end
        end else begin
            for (int k = NUM_CNT; k >= 1; k--) begin
                rrIdx = (int'(last_q) + k) % NUM_CNT;
                if ((cnt_intr25 & (NUM_CNT'(1) << rrIdx)) != '0) begin
                    winIdx = SRC_W'(rrIdx);
                end
            end
        end
        winStatus = 6'(cnt_intr_reg25 >> (6 * int'(winIdx)));
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        last_d    = last_q;
        irq_d     = irq_q;
        src_d     = src_q;
        status_d  = status_q;
        clr_d     = '0;
        timeout_d = timeout_q;

        if (timeout_clr25) begin
            timeout_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (sched_en25 && winValid) begin
                    state_d  = ASSERT;
                    irq_d    = 1'b1;
                    count_d  = TO_W'(1);
                    src_d    = winIdx;
                    status_d = winStatus;
                    if (prio_mode25) begin
                        last_d = winIdx;
                    end
                end
            end
            ASSERT: begin
                // An ack on the final allowed cycle wins over the timeout.
                if (irq_ack25) begin
                    state_d = CLEAR;
                    irq_d   = 1'b0;
                    clr_d   = NUM_CNT'(1) << src_q;
                    count_d = '0;
                end else if (count_q == TO_W'(ACK_TIMEOUT)) begin
                    state_d   = CLEAR;
                    irq_d     = 1'b0;
                    clr_d     = NUM_CNT'(1) << src_q;
                    count_d   = '0;
                    timeout_d = 1'b1;
                end else begin
                    count_d = count_q + TO_W'(1);
                end
            end
            CLEAR: begin
                state_d = WAIT;
            end
            WAIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk25) begin
        if (p_reset25) begin
            state_q   <= IDLE;
            count_q   <= '0;
            last_q    <= SRC_W'(NUM_CNT - 1);
            irq_q     <= 1'b0;
            src_q     <= '0;
            status_q  <= '0;
            clr_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            last_q    <= last_d;
            irq_q     <= irq_d;
            src_q     <= src_d;
            status_q  <= status_d;
            clr_q     <= clr_d;
            timeout_q <= timeout_d;
        end
    end

    assign irq25             = irq_q;
    assign irq_src25         = src_q;
    assign irq_status25      = status_q;
    assign clear_interrupt25 = clr_q;
    assign timeout25         = timeout_q;

endmodule

// File: tb/tb_ttc_intr_sched25.sv
// Scoreboard bench for ttc_intr_sched25: directed scenarios push expected grants
// and clears; a negedge monitor pops and compares them as the DUT presents them.
module tb_ttc_intr_sched25;

    logic        pclk25;
    logic        p_reset25;
    logic [2:0]  cnt_intr25;
    logic [17:0] cnt_intr_reg25;
    logic        sched_en25;
    logic        prio_mode25;
    logic        irq_ack25;
    logic        timeout_clr25;
    logic        irq25;
    logic [1:0]  irq_src25;
    logic [5:0]  irq_status25;
    logic [2:0]  clear_interrupt25;
    logic        timeout25;

    typedef struct {
        bit       isClear;
        bit [1:0] src;
        bit [5:0] status;
        bit [2:0] clr;
        bit       tout;
    } expEvent_t;

    expEvent_t sbq[$];
    int        checks = 0;
    int        errors = 0;
    logic      prevIrq = 1'b0;

    ttc_intr_sched25 #(
        .NUM_CNT(3), .SRC_W(2), .ACK_TIMEOUT(8), .TO_W(8)
    ) dut (
        .pclk25(pclk25),
        .p_reset25(p_reset25),
        .cnt_intr25(cnt_intr25),
        .cnt_intr_reg25(cnt_intr_reg25),
        .sched_en25(sched_en25),
        .prio_mode25(prio_mode25),
        .irq_ack25(irq_ack25),
        .timeout_clr25(timeout_clr25),
        .irq25(irq25),
        .irq_src25(irq_src25),
        .irq_status25(irq_status25),
        .clear_interrupt25(clear_interrupt25),
        .timeout25(timeout25)
    );

    initial pclk25 = 1'b0;
    always #5 pclk25 = ~pclk25;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic pushGrant(input bit [1:0] src, input bit [5:0] status);
        expEvent_t e;
        e.isClear = 1'b0; e.src = src; e.status = status; e.clr = '0; e.tout = 1'b0;
        sbq.push_back(e);
    endtask

    task automatic pushClear(input bit [2:0] clr, input bit tout);
        expEvent_t e;
        e.isClear = 1'b1; e.src = '0; e.status = '0; e.clr = clr; e.tout = tout;
        sbq.push_back(e);
    endtask

    // Returns on the first negedge where irq25 is high.
    task automatic waitIrq(input int maxCycles);
        int n = 0;
        @(negedge pclk25);
        while (irq25 !== 1'b1 && n < maxCycles) begin
            @(negedge pclk25);
            n++;
        end
        if (irq25 !== 1'b1) checkOutput("irqWait", 32'(irq25), 32'd1);
    endtask

    // Ack lands in ASSERT cycle d+1 when called at the first irq negedge.
    task automatic serveAck(input int d);
        repeat (d) @(posedge pclk25);
        #1 irq_ack25 = 1'b1;
        @(posedge pclk25);
        #1 irq_ack25 = 1'b0;
    endtask

    task automatic applyStimulus(input logic en, input logic mode, input logic [2:0] req);
        sched_en25  = en;
        prio_mode25 = mode;
        cnt_intr25  = req;
    endtask

    // Monitor: grant = irq25 rising edge, clear = any nonzero clear pulse.
    initial begin
        expEvent_t e;
        forever begin
            @(negedge pclk25);
            if (irq25 === 1'b1 && prevIrq !== 1'b1) begin
                if (sbq.size() == 0) begin
                    checkOutput("unexpectedGrant", 32'(irq_src25), 32'hFF);
                end else begin
                    e = sbq.pop_front();
                    checkOutput("grantOrder", 32'(e.isClear), 32'd0);
                    checkOutput("grantSrc", 32'(irq_src25), 32'(e.src));
                    checkOutput("grantStatus", 32'(irq_status25), 32'(e.status));
                end
            end
            if (clear_interrupt25 !== 3'b000) begin
                checkOutput("clearMatchesSrc", 32'(clear_interrupt25), 32'(3'b001 << irq_src25));
                if (sbq.size() == 0) begin
                    checkOutput("unexpectedClear", 32'(clear_interrupt25), 32'd0);
                end else begin
                    e = sbq.pop_front();
                    checkOutput("clearOrder", 32'(e.isClear), 32'd1);
                    checkOutput("clearPulse", 32'(clear_interrupt25), 32'(e.clr));
                    checkOutput("clearTimeout", 32'(timeout25), 32'(e.tout));
                end
            end
            prevIrq = irq25;
        end
    end

    initial begin
        int hiCycles;
        p_reset25      = 1'b1;
        irq_ack25      = 1'b0;
        timeout_clr25  = 1'b0;
        cnt_intr_reg25 = {6'h35, 6'h2A, 6'h11};
        applyStimulus(1'b0, 1'b0, 3'b000);
        repeat (2) @(posedge pclk25);
        #1 p_reset25 = 1'b0;
        @(negedge pclk25);
        checkOutput("rstIrq", 32'(irq25), 32'd0);
        checkOutput("rstSrc", 32'(irq_src25), 32'd0);
        checkOutput("rstStatus", 32'(irq_status25), 32'd0);
        checkOutput("rstClear", 32'(clear_interrupt25), 32'd0);
        checkOutput("rstTimeout", 32'(timeout25), 32'd0);

        $display("[TB] fixed priority");
        pushGrant(2'd1, 6'h2A); pushClear(3'b010, 1'b0);
        pushGrant(2'd2, 6'h35); pushClear(3'b100, 1'b0);
        applyStimulus(1'b1, 1'b0, 3'b110);
        waitIrq(10);
        serveAck(1);
        cnt_intr25 = 3'b100;
        waitIrq(10);
        serveAck(0);
        cnt_intr25 = 3'b000;

        $display("[TB] round robin");
        pushGrant(2'd0, 6'h11); pushClear(3'b001, 1'b0);
        pushGrant(2'd1, 6'h2A); pushClear(3'b010, 1'b0);
        pushGrant(2'd2, 6'h35); pushClear(3'b100, 1'b0);
        pushGrant(2'd0, 6'h11); pushClear(3'b001, 1'b0);
        applyStimulus(1'b1, 1'b1, 3'b111);
        for (int g = 0; g < 4; g++) begin
            waitIrq(10);
            serveAck(2);
        end
        cnt_intr25 = 3'b000;

        $display("[TB] ack timeout");
        pushGrant(2'd0, 6'h11); pushClear(3'b001, 1'b1);
        applyStimulus(1'b1, 1'b0, 3'b001);
        waitIrq(10);
        hiCycles = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge pclk25);
            if (irq25 !== 1'b1) break;
            hiCycles++;
        end
        cnt_intr25 = 3'b000;
        checkOutput("irqHighCycles", 32'(hiCycles), 32'd8);
        repeat (3) @(negedge pclk25);
        checkOutput("timeoutSticky", 32'(timeout25), 32'd1);
        timeout_clr25 = 1'b1;
        @(posedge pclk25);
        #1 timeout_clr25 = 1'b0;
        @(negedge pclk25);
        checkOutput("timeoutCleared", 32'(timeout25), 32'd0);

        $display("[TB] ack on last cycle");
        pushGrant(2'd2, 6'h35); pushClear(3'b100, 1'b0);
        applyStimulus(1'b1, 1'b0, 3'b100);
        waitIrq(10);
        serveAck(7);
        cnt_intr25 = 3'b000;
        repeat (3) @(negedge pclk25);
        checkOutput("lateAckNoTimeout", 32'(timeout25), 32'd0);

        $display("[TB] enable");
        applyStimulus(1'b0, 1'b0, 3'b001);
        repeat (5) @(negedge pclk25);
        checkOutput("disabledNoIrq", 32'(irq25), 32'd0);
        pushGrant(2'd0, 6'h11); pushClear(3'b001, 1'b0);
        sched_en25 = 1'b1;
        waitIrq(10);
        sched_en25 = 1'b0;
        serveAck(1);
        cnt_intr25 = 3'b000;
        repeat (3) @(negedge pclk25);

        $display("[TB] reset mid-assert");
        pushGrant(2'd1, 6'h2A);
        applyStimulus(1'b1, 1'b1, 3'b010);
        waitIrq(10);
        @(posedge pclk25);
        #1 p_reset25 = 1'b1;
        @(posedge pclk25);
        @(negedge pclk25);
        checkOutput("midRstIrq", 32'(irq25), 32'd0);
        checkOutput("midRstSrc", 32'(irq_src25), 32'd0);
        checkOutput("midRstStatus", 32'(irq_status25), 32'd0);
        checkOutput("midRstClear", 32'(clear_interrupt25), 32'd0);
        pushGrant(2'd0, 6'h11); pushClear(3'b001, 1'b0);
        p_reset25  = 1'b0;
        cnt_intr25 = 3'b111;
        waitIrq(10);
        serveAck(0);
        cnt_intr25 = 3'b000;

        repeat (6) @(negedge pclk25);
        checkOutput("queueDrained", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
